// File: rtl/vga_line_fetch.sv
// ---------------------------------------------------------------------------
// vga_line_fetch
//
// Framebuffer prefetch stage for the VGA renderer. Fetches one packed cell
// row (2 bits per cell, 16 cells per 32-bit word) from SDRAM over an
// Avalon-MM read master into a two-bank line buffer, one cell row ahead of
// the beam, and presents the word under the beam.
//
// Configuration macro:
//   LINE_FETCH_PIPELINE_EN  defined   : up to 4 reads outstanding, back-to-back
//                           undefined : one read outstanding at a time
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   px_x, px_y          beam pixel column / line
//   address, read       Avalon read request (word address)
//   waitrequest         Avalon stall
//   readdata,
//   readdatavalid       Avalon read return
//   buffer              packed word under the beam (cell k at [2k+1:2k])
//   buffer_ptr          cell index within buffer
//   busy                a row fetch is in progress
//   underrun            sticky: a row was shown before its fetch completed
// ---------------------------------------------------------------------------
module vga_line_fetch #(
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned GRID_W    = 320,
    parameter int unsigned GRID_H    = 240,
    parameter int unsigned VLAST     = 524
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [9:0]        px_x,
    input  logic [9:0]        px_y,
    output logic [ADDR_W-1:0] address,
    output logic              read,
    input  logic              waitrequest,
    input  logic [31:0]       readdata,
    input  logic              readdatavalid,
    output logic [31:0]       buffer,
    output logic [4:0]        buffer_ptr,
    output logic              busy,
    output logic              underrun
);

    localparam int unsigned WORDS = GRID_W / 16;
    localparam int unsigned CNT_W = $clog2(WORDS + 1);
`ifdef LINE_FETCH_PIPELINE_EN
    localparam int unsigned CAP = 4;
`else
    localparam int unsigned CAP = 1;
`endif

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]        state;
    logic [9:0]        px_y_q;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  returned;
    logic [CNT_W-1:0]  outstanding;
    logic [ADDR_W-1:0] row_addr;
    logic              target;
    logic [1:0]        bank_valid;
    logic [31:0]       bank_ram [2][WORDS];

    logic [9:0]        next_row;
    logic              fetch_req;
    logic              fetch_bank;
    logic [9:0]        fetch_row;
    logic              accept;
    logic              ret_ok;
    logic              last_ret;
    logic              active;
    logic              disp_bank;

    assign next_row    = {1'b0, px_y[9:1]} + 10'd1;
    assign outstanding = issued - returned;
    assign active      = (px_x < 10'd640) && (px_y < 10'd480);
    assign disp_bank   = px_y[1];

    // Trigger decode: a line change that starts a row fetch, plus its target.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        fetch_req  = 1'b0;
        fetch_bank = 1'b0;
        fetch_row  = 10'd0;
        if (px_y != px_y_q) begin
            if (px_y == 10'(VLAST)) begin
                fetch_req = 1'b1;
            end else if (!px_y[0] && (next_row < 10'(GRID_H))) begin
                fetch_req  = 1'b1;
                fetch_row  = next_row;
                fetch_bank = next_row[0];
            end
        end
    end

    // Request is purely a function of registered state, so address and read
    // hold still for as long as waitrequest stalls them.
    assign read     = (state == ISSUE) && (issued < CNT_W'(WORDS)) &&
                      (outstanding < CNT_W'(CAP));
    assign address  = row_addr + ADDR_W'(issued);
    assign accept   = read && !waitrequest;
    // Returns with nothing outstanding (stray or pre-reset) are dropped.
    assign ret_ok   = readdatavalid && (state != IDLE) && (outstanding != '0);
    assign last_ret = ret_ok && (returned == CNT_W'(WORDS - 1));
    assign busy     = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: state registers use non-blocking assignments so every
            // always_ff samples the pre-edge values regardless of order.
            state      <= IDLE;
            px_y_q     <= '0;
            issued     <= '0;
            returned   <= '0;
            row_addr   <= '0;
            target     <= 1'b0;
            bank_valid <= '0;
            underrun   <= 1'b0;
            buffer     <= '0;
            buffer_ptr <= '0;
        end else begin
            px_y_q     <= px_y;
            buffer_ptr <= {1'b0, px_x[4:1]};
            buffer     <= (active && bank_valid[disp_bank]) ?
                          bank_ram[disp_bank][px_x[9:5]] : 32'd0;

            if ((fetch_req && state != IDLE) || (active && !bank_valid[disp_bank]))
                underrun <= 1'b1;

            if (state == IDLE) begin
                if (fetch_req) begin
                    state                  <= ISSUE;
                    issued                 <= '0;
                    returned               <= '0;
                    target                 <= fetch_bank;
                    row_addr               <= ADDR_W'(BASE_ADDR) +
                                              ADDR_W'(fetch_row) * ADDR_W'(WORDS);
                    bank_valid[fetch_bank] <= 1'b0;
                end
            end else begin
                if (accept) begin
                    issued <= issued + 1'b1;
                    if (issued == CNT_W'(WORDS - 1))
                        state <= DRAIN;
                end
                if (ret_ok)
                    returned <= returned + 1'b1;
                if (last_ret) begin
                    bank_valid[target] <= 1'b1;
                    state              <= IDLE;
                end
            end
        end
    end

    // NOTE: the line buffer RAM is deliberately left out of reset; bank_valid
    // already masks stale contents, and a reset RAM would not map to block RAM.
    always_ff @(posedge clock) begin
        if (ret_ok)
            bank_ram[target][returned] <= readdata;
    end

endmodule

// File: tb/tb_vga_line_fetch.sv
// ---------------------------------------------------------------------------
// tb_vga_line_fetch
//
// Self-checking bench for vga_line_fetch. An Avalon memory model returns
// word = address after a programmable latency and can stall one request.
// Expected addresses are queued when the bench moves px_y and checked as the
// DUT issues reads; expected buffer words are queued when px_x is driven and
// checked one cycle later.
// ---------------------------------------------------------------------------
module tb_vga_line_fetch;

    localparam int BASE   = 32'h1000;
    localparam int WORDS  = 20;
    localparam int GRID_H = 240;
    localparam int VLAST  = 524;

    logic        clock;
    logic        reset;
    logic [9:0]  px_x;
    logic [9:0]  px_y;
    logic [15:0] address;
    logic        read;
    logic        waitrequest;
    logic [31:0] readdata;
    logic        readdatavalid;
    logic [31:0] buffer;
    logic [4:0]  buffer_ptr;
    logic        busy;
    logic        underrun;

    vga_line_fetch #(
        .BASE_ADDR(BASE), .ADDR_W(16), .GRID_W(320), .GRID_H(GRID_H), .VLAST(VLAST)
    ) dut (
        .clock(clock), .reset(reset), .px_x(px_x), .px_y(px_y),
        .address(address), .read(read), .waitrequest(waitrequest),
        .readdata(readdata), .readdatavalid(readdatavalid),
        .buffer(buffer), .buffer_ptr(buffer_ptr), .busy(busy), .underrun(underrun)
    );

    initial begin
        clock = 1'b0;
        forever #10 clock = ~clock;
    end

    typedef struct {
        logic [15:0] addr;
        int          ready;
    } pend_t;

    int          checks    = 0;
    int          failures  = 0;
    int          cyc       = 0;
    int          latency   = 2;
    int          stall_idx = -1;
    int          stall_left = 0;
    int          stray_left = 0;
    int          acc_in_fetch = 0;
    bit          mem_flush = 1'b0;
    bit          model_busy = 1'b0;
    int          cur_y;
    pend_t       pend_q[$];
    logic [15:0] addr_q[$];
    int          acc_cyc_q[$];
    logic [31:0] exp_q[$];
    logic [4:0]  ptr_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%h expected=0x%h", tag, got, exp);
        end
    endtask

    // Avalon slave model; all decisions are made on the falling edge for the
    // rising edge that follows.
    initial begin
        pend_t p;
        waitrequest   = 1'b0;
        readdatavalid = 1'b0;
        readdata      = '0;
        forever begin
            @(negedge clock);
            cyc++;
            readdatavalid = 1'b0;
            waitrequest   = 1'b0;
            if (mem_flush) begin
                pend_q.delete();
            end else begin
                if (stray_left > 0) begin
                    readdata      = 32'hDEAD_BEEF;
                    readdatavalid = 1'b1;
                    stray_left--;
                end else if (pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
                    p             = pend_q.pop_front();
                    readdata      = 32'(p.addr);
                    readdatavalid = 1'b1;
                end
                if (read && stall_left > 0 && acc_in_fetch == stall_idx) begin
                    waitrequest = 1'b1;
                    stall_left--;
                    check("stall_addr", address, 32'h1002);
                    check("stall_read", read, 1);
                end else if (read) begin
                    if (addr_q.size() == 0) begin
                        check("unexpected_read", address, 32'hFFFF_FFFF);
                    end else begin
                        check("address", address, addr_q.pop_front());
                    end
                    p.addr  = address;
                    p.ready = cyc + latency;
                    pend_q.push_back(p);
                    acc_cyc_q.push_back(cyc);
                    acc_in_fetch++;
                end
            end
        end
    end

    function automatic bit fetch_of(input int y, output int row);
        row = 0;
        if (y == VLAST) return 1'b1;
        if (y % 2 == 0 && y / 2 + 1 < GRID_H) begin
            row = y / 2 + 1;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic set_y(input int y);
        int row;
        if (y != cur_y && fetch_of(y, row) && !model_busy) begin
            for (int w = 0; w < WORDS; w++)
                addr_q.push_back(16'(BASE + row * WORDS + w));
            model_busy   = 1'b1;
            acc_in_fetch = 0;
            acc_cyc_q.delete();
        end
        cur_y = y;
        px_y  = 10'(y);
    endtask

    task automatic show(input int x, input logic [31:0] exp_buf);
        px_x = 10'(x);
        exp_q.push_back(exp_buf);
        ptr_q.push_back(5'((x >> 1) & 15));
        @(negedge clock);
        check("buffer", buffer, exp_q.pop_front());
        check("buffer_ptr", buffer_ptr, 32'(ptr_q.pop_front()));
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clock);
        while (busy && n < 5000) begin
            @(negedge clock);
            n++;
        end
        check("busy_drop", busy, 0);
        check("addr_q_empty", addr_q.size(), 0);
        model_busy = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        mem_flush = 1'b1;
        repeat (2) @(negedge clock);
        addr_q.delete();
        model_busy = 1'b0;
        px_x  = 10'd700;
        cur_y = 1;
        px_y  = 10'd1;
        @(negedge clock);
        reset     = 1'b0;
        mem_flush = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        px_x  = 10'd700;
        px_y  = 10'd523;
        cur_y = 523;
        repeat (2) @(negedge clock);
        check("rst_read", read, 0);
        check("rst_address", address, 0);
        check("rst_buffer", buffer, 0);
        check("rst_buffer_ptr", buffer_ptr, 0);
        check("rst_busy", busy, 0);
        check("rst_underrun", underrun, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Row 0 into bank 0, third request stalled for 5 cycles.
        stall_idx  = 2;
        stall_left = 5;
        set_y(524);
        @(negedge clock);
        check("read_rise", read, 1);
        check("busy_rise", busy, 1);
        wait_idle();
        check("stall_consumed", stall_left, 0);

        // Sweep bank 0 while row 1 streams into bank 1.
        set_y(0);
        for (int w = 0; w < WORDS; w++)
            show(w * 32 + 2 * (w % 16), 32'(BASE + w));
        px_x = 10'd700;
        wait_idle();

        // Row 6 into bank 0; check request spacing on this fetch.
        set_y(8);
        wait_idle();
        set_y(10);
        wait_idle();
        for (int i = 0; i < 3; i++) begin
`ifdef LINE_FETCH_PIPELINE_EN
            check("b2b_accept", acc_cyc_q[i + 1] - acc_cyc_q[i], 1);
`else
            check("accept_gap_ge3", 32'(acc_cyc_q[i + 1] - acc_cyc_q[i] >= 3), 1);
`endif
        end
        set_y(12);
        show(100, 32'h107B);
        px_x = 10'd700;
        wait_idle();
        check("no_underrun", underrun, 0);

        // Row 1 starved by a very slow memory.
        latency = 4000;
        set_y(0);
        repeat (6) @(negedge clock);
        set_y(2);
        show(100, 32'h0);
        check("underrun_set", underrun, 1);
        px_x = 10'd700;

        // Reset with reads outstanding, then stray returns.
        do_reset();
        check("underrun_clear", underrun, 0);
        check("post_rst_busy", busy, 0);
        stray_left = 3;
        repeat (5) @(negedge clock);
        check("stray_read", read, 0);
        check("stray_busy", busy, 0);

        // Clean refetch of row 1 must land word-aligned in bank 1.
        latency = 2;
        set_y(0);
        wait_idle();
        set_y(2);
        for (int w = 0; w < 4; w++)
            show(w * 32 + 2 * w, 32'(BASE + WORDS + w));
        px_x = 10'd700;
        wait_idle();
        check("final_underrun", underrun, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_line_fetch.md
# vga_line_fetch

Framebuffer prefetch stage feeding the VGA renderer. Reads packed 2-bit cell rows (16 cells per 32-bit word) from SDRAM through an Avalon-MM read master into a two-bank line buffer, one cell row ahead of the beam. Presents the word under the beam plus the cell index within it as `buffer`/`buffer_ptr`. Each cell covers 2×2 pixels of the 640×480 active area.

## Interface
- `BASE_ADDR`, 0: word address of cell row 0, word 0.
- `ADDR_W`, 16: Avalon word-address width.
- `GRID_W`, 320: cells per row; multiple of 16. `WORDS = GRID_W/16` (20).
- `GRID_H`, 240: cell rows.
- `VLAST`, 524: last line of vertical blank (prefetch line for row 0).

Ports:
- `clock  in  1`: 50 MHz system clock.
- `reset  in  1`: asynchronous, active-high.
- `px_x  in  10`: beam pixel column, 0..639 while active.
- `px_y  in  10`: beam line, 0..524.
- `address  out  ADDR_W`: Avalon read word address.
- `read  out  1`: Avalon read request.
- `waitrequest  in  1`: Avalon stall.
- `readdata  in  32`: Avalon return data.
- `readdatavalid  in  1`: Avalon return strobe.
- `buffer  out  32`: packed word under the beam; cell k at bits [2k+1:2k].
- `buffer_ptr  out  5`: cell index within `buffer`, 0..15.
- `busy  out  1`: fetch in progress.
- `underrun  out  1`: sticky; a row was displayed before its fetch completed.

## Operation
- Two banks of `WORDS`×32 bits, plus `bank_valid[1:0]`. The display bank is `px_y[1]`, which equals cell row `px_y>>1` mod 2.
- **Trigger:** `px_y` differs from registered `px_y_q`.
  - New `px_y` = `VLAST`: fetch row 0 into bank 0.
  - New `px_y` is even and `(px_y>>1)+1 < GRID_H`: fetch row `(px_y>>1)+1` into bank `((px_y>>1)+1)&1`.
  - Any other line change: no fetch.
- **Fetch start:** clear `bank_valid` of the target bank, latch row and bank, zero the issue and return counters.
- **Addressing:** word w of row r is at `BASE_ADDR + r*WORDS + w`, mod 2^`ADDR_W`.
- **FSM:**
  - IDLE: on trigger, go to ISSUE.
  - ISSUE: assert `read` with the current address while issued < `WORDS` and outstanding < cap. A request is accepted on a cycle with `read && !waitrequest`; then issued++. `address` and `read` hold stable while `waitrequest` is high. After the last accept, go to DRAIN.
  - DRAIN: wait until returned = `WORDS`, then go to IDLE.
- **Returns:** each `readdatavalid` writes `readdata` to target bank entry `returned`, then returned++. This happens in ISSUE or DRAIN. When the last return is written, set `bank_valid[target]` on the same edge.
- **Outstanding count:** issued − returned. When an accept and a return happen in the same cycle, the count is unchanged.
- **Trigger while busy:** the trigger is dropped, `underrun` is set, and the current fetch runs to completion.
- **Underrun:** also set if the display bank is invalid on any cycle with `px_x < 640` and `px_y < 480`. `underrun` clears only on reset.
- **Output:** cell x = `px_x[9:1]`; word = `px_x[9:5]`; `buffer_ptr = {1'b0, px_x[4:1]}`.
  - `buffer` = display bank entry at that word.
  - If the display bank is invalid, or `px_x >= 640`, or `px_y >= 480`, then `buffer = 0` (empty).
- **Reset** (any time, including mid-fetch): FSM to IDLE; counters, `bank_valid` and `px_y_q` cleared. Returns arriving after reset are ignored. Bank RAM contents are not cleared.

## Timing
- Reset values: `read`=0, `address`=0, `buffer`=0, `buffer_ptr`=0, `busy`=0, `underrun`=0.
- `buffer` and `buffer_ptr` are registered: they reflect `px_x`/`px_y` sampled one cycle earlier.
- Trigger detection uses `px_y_q`. `read` first rises on the cycle after the edge where `px_y` changes.
- `busy` is high from the cycle after the trigger until the cycle after the last return.
- Budget: a row fetch must finish within 2 lines (3200 clocks). With zero-wait memory and single outstanding, a fetch takes ≤ `WORDS`×(latency+1) cycles.
- A `readdatavalid` with no outstanding request is ignored.

## Configuration
- `LINE_FETCH_PIPELINE_EN`:
  - Defined: outstanding cap = 4; back-to-back accepts are allowed.
  - Undefined: cap = 1; `read` stays low until the previous `readdatavalid`, and the next request issues no earlier than the cycle after it.
- Addresses, data placement and output behaviour are identical in both builds.

## Test plan
- `BASE_ADDR`=0x1000; `px_y` steps 523→524, memory returns word = address → addresses 0x1000..0x1013 in order; bank 0 holds 0x1000..0x1013; `busy` drops; `bank_valid[0]`=1.
- `px_y` 8→10 → row 6 fetched into bank 0 at 0x1078..0x108B. With `px_y`=12, `px_x`=100, the next cycle shows `buffer`=0x107B and `buffer_ptr`=2.
- `waitrequest` held high 5 cycles on the 3rd request → `address`=0x1002 and `read` are stable throughout; no word is skipped or duplicated.
- Memory latency 4000 cycles on row 1 → at `px_y`=2 in active region, `underrun`=1 and `buffer`=0; after reset, `underrun`=0.
- Assert reset with 3 reads outstanding, release, then deliver 3 stray `readdatavalid` → no bank writes, `read`=0, state IDLE.
- With the macro defined, zero-wait memory and latency 2 → 4 accepts on consecutive cycles. With it undefined → `read` pulses spaced ≥3 cycles.
